decode_hazard_stage: RTL

- Consumer end of the FE/DE latch. Takes PC, IR and fetch-stall from the fetch stage, decodes the IR, and reads register operands.
- Tracks in-flight destination writes with a per-register scoreboard.
- Generates the two stall signals the fetch stage consumes: branch-stall and dependency-stall.
- Drives the DE/EX latch and accepts register writeback from the WB stage.

---
 rtl/decode_hazard_stage_pkg.sv | 85 ++++++++
 rtl/decode_hazard_stage_scoreboard.sv | 55 +++++
 rtl/decode_hazard_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/decode_hazard_stage_pkg.sv
// Shared decode definitions for the decode/hazard stage: opcode map, IR field
// positions, per-opcode operand usage and the stage FSM encoding.
package decode_hazard_stage_pkg;

    localparam int unsigned OPC_W = 8;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned IMM_W = 16;

    // IR field bit positions
    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned DEST_MSB = 23;
    localparam int unsigned DEST_LSB = 20;
    localparam int unsigned SRC1_MSB = 19;
    localparam int unsigned SRC1_LSB = 16;
    localparam int unsigned SRC2_MSB = 11;
    localparam int unsigned SRC2_LSB = 8;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_LSB  = 0;

    // Opcode map
    localparam logic [OPC_W-1:0] OP_NOP  = 8'hFF;
    localparam logic [OPC_W-1:0] OP_ADD  = 8'h01;
    localparam logic [OPC_W-1:0] OP_SUB  = 8'h02;
    localparam logic [OPC_W-1:0] OP_AND  = 8'h03;
    localparam logic [OPC_W-1:0] OP_OR   = 8'h04;
    localparam logic [OPC_W-1:0] OP_ADDI = 8'h08;
    localparam logic [OPC_W-1:0] OP_MOVI = 8'h09;
    localparam logic [OPC_W-1:0] OP_LDW  = 8'h10;
    localparam logic [OPC_W-1:0] OP_STW  = 8'h11;

    // Branch class: 0x20 unconditional, 0x21-0x27 compare two regs, 0x28-0x2B register target
    localparam logic [OPC_W-1:0] OP_BR_FIRST = 8'h20;
    localparam logic [OPC_W-1:0] OP_BR_CMP_F = 8'h21;
    localparam logic [OPC_W-1:0] OP_BR_CMP_L = 8'h27;
    localparam logic [OPC_W-1:0] OP_BR_LAST  = 8'h2B;

    typedef struct packed {
        logic use_src1;
        logic use_src2;
        logic writes_dest;
        logic is_branch;
    } op_info_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DEP_STALL = 2'd1,
        ST_BR_WAIT   = 2'd2
    } state_t;

    // Operand usage lookup per opcode
    function automatic op_info_t decode_op(input logic [OPC_W-1:0] op);
        op_info_t info;
        info = '0;
        if (op >= OP_BR_FIRST && op <= OP_BR_LAST) begin
            info.is_branch = 1'b1;
            if (op >= OP_BR_CMP_F && op <= OP_BR_CMP_L) begin
                info.use_src1 = 1'b1;
                info.use_src2 = 1'b1;
            end else if (op > OP_BR_CMP_L) begin
                info.use_src1 = 1'b1;
            end
        end else begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    info.use_src1    = 1'b1;
                    info.use_src2    = 1'b1;
                    info.writes_dest = 1'b1;
                end
                OP_ADDI, OP_LDW: begin
                    info.use_src1    = 1'b1;
                    info.writes_dest = 1'b1;
                end
                OP_MOVI: info.writes_dest = 1'b1;
                OP_STW: begin
                    info.use_src1 = 1'b1;
                    info.use_src2 = 1'b1;
                end
                default: info = '0;
            endcase
        end
        return info;
    endfunction

endpackage

// File: rtl/decode_hazard_stage_scoreboard.sv
// Per-register in-flight write counters. Queries see counts after this edge's
// writeback decrement; an increment and decrement on one index net together.
module decode_scoreboard
    import decode_hazard_stage_pkg::*;
#(
    parameter int unsigned REG_COUNT = 16,
    parameter int unsigned CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dec_en,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic [IDX_W-1:0] q_src1,
    input  logic [IDX_W-1:0] q_src2,
    input  logic [IDX_W-1:0] q_dest,
    output logic             busy1_c,
    output logic             busy2_c,
    output logic             full_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt     [REG_COUNT];
    logic [CNT_W-1:0] cnt_dec [REG_COUNT];

    // Apply the writeback decrement, saturating at zero
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            cnt_dec[i] = cnt[i];
            if (dec_en && dec_idx == IDX_W'(i) && cnt[i] != '0)
                cnt_dec[i] = cnt[i] - CNT_W'(1);
        end
    end

    // Hazard queries against post-writeback counts
    always_comb begin
        busy1_c = (cnt_dec[q_src1] != '0);
        busy2_c = (cnt_dec[q_src2] != '0);
        full_c  = (cnt_dec[q_dest] == CNT_MAX);
    end

    // Counter update; increment is only requested when the count is below max
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) cnt[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < REG_COUNT; i++)
                cnt[i] <= cnt_dec[i] + ((inc_en && inc_idx == IDX_W'(i)) ? CNT_W'(1) : CNT_W'(0));
        end
    end

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode/hazard stage: decodes the FE/DE entry, reads operands with WB bypass,
// tracks in-flight writes and raises dependency/branch stalls to fetch.
// Optional build macro: DECODE_PERF_CNT_EN enables the stall-cycle counters.
module decode_hazard_stage
    import decode_hazard_stage_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 16,
    parameter int unsigned IR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned REG_COUNT    = 16,
    parameter int unsigned SB_CNT_WIDTH = 2
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic                  I_LOCK,
    input  logic                  I_FRAMESTALL,
    input  logic [PC_WIDTH-1:0]   I_PC,
    input  logic [IR_WIDTH-1:0]   I_IR,
    input  logic                  I_FetchStall,
    input  logic                  I_BranchAddrSelect,
    input  logic                  I_WBEnable,
    input  logic [IDX_W-1:0]      I_WBRegIdx,
    input  logic [DATA_WIDTH-1:0] I_WBData,
    output logic                  O_LOCK,
    output logic                  O_BranchStallSignal,
    output logic                  O_DepStallSignal,
    output logic                  O_DEValid,
    output logic [PC_WIDTH-1:0]   O_PC,
    output logic [OPC_W-1:0]      O_Opcode,
    output logic [IDX_W-1:0]      O_DestRegIdx,
    output logic [DATA_WIDTH-1:0] O_Src1Value,
    output logic [DATA_WIDTH-1:0] O_Src2Value,
    output logic [IMM_W-1:0]      O_Imm,
    output logic [31:0]           O_DepStallCycles,
    output logic [31:0]           O_BrStallCycles
);

    logic [DATA_WIDTH-1:0] rf [REG_COUNT];

    logic [OPC_W-1:0]      opc;
    logic [IDX_W-1:0]      dest_idx, src1_idx, src2_idx;
    logic [IMM_W-1:0]      imm;
    op_info_t              info;
    logic                  bubble_c, hazard_c, issue_c;
    logic                  busy1_c, busy2_c, dest_full_c;
    logic [DATA_WIDTH-1:0] src1_val_c, src2_val_c;
    state_t                state, state_nxt;
    logic                  valid_nxt, dep_nxt, br_nxt;

    // IR field extraction and hazard qualification
    always_comb begin
        opc      = I_IR[OPC_MSB:OPC_LSB];
        dest_idx = I_IR[DEST_MSB:DEST_LSB];
        src1_idx = I_IR[SRC1_MSB:SRC1_LSB];
        src2_idx = I_IR[SRC2_MSB:SRC2_LSB];
        imm      = I_IR[IMM_MSB:IMM_LSB];
        info     = decode_op(opc);
        bubble_c = I_FetchStall || (opc == OP_NOP);
        hazard_c = (info.use_src1 && busy1_c) || (info.use_src2 && busy2_c) ||
                   (info.writes_dest && dest_full_c);
    end

    // Operand read with same-edge writeback bypass
    always_comb begin
        src1_val_c = rf[src1_idx];
        src2_val_c = rf[src2_idx];
        if (I_WBEnable && I_WBRegIdx == src1_idx) src1_val_c = I_WBData;
        if (I_WBEnable && I_WBRegIdx == src2_idx) src2_val_c = I_WBData;
    end

    decode_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .CNT_W     (SB_CNT_WIDTH)
    ) u_scoreboard (
        .clk     (I_CLOCK),
        .rst     (I_RESET),
        .en      (!I_FRAMESTALL),
        .dec_en  (I_WBEnable),
        .dec_idx (I_WBRegIdx),
        .inc_en  (issue_c && info.writes_dest),
        .inc_idx (dest_idx),
        .q_src1  (src1_idx),
        .q_src2  (src2_idx),
        .q_dest  (dest_idx),
        .busy1_c (busy1_c),
        .busy2_c (busy2_c),
        .full_c  (dest_full_c)
    );

    // Next-state and next-output decision; lock low holds FSM and stalls
    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        issue_c   = 1'b0;
        dep_nxt   = O_DepStallSignal;
        br_nxt    = O_BranchStallSignal;
        if (I_LOCK) begin
            case (state)
                ST_RUN, ST_DEP_STALL: begin
                    if (bubble_c) begin
                        state_nxt = ST_RUN;
                        dep_nxt   = 1'b0;
                        br_nxt    = 1'b0;
                    end else if (hazard_c) begin
                        state_nxt = ST_DEP_STALL;
                        dep_nxt   = 1'b1;
                        br_nxt    = info.is_branch;
                    end else begin
                        issue_c   = 1'b1;
                        valid_nxt = 1'b1;
                        dep_nxt   = 1'b0;
                        br_nxt    = info.is_branch;
                        state_nxt = info.is_branch ? ST_BR_WAIT : ST_RUN;
                    end
                end
                ST_BR_WAIT: begin
                    dep_nxt = 1'b0;
                    if (I_BranchAddrSelect) begin
                        br_nxt    = 1'b0;
                        state_nxt = ST_RUN;
                    end else begin
                        br_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    dep_nxt   = 1'b0;
                    br_nxt    = 1'b0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET)            state <= ST_RUN;
        else if (!I_FRAMESTALL) state <= state_nxt;
    end

    // Register file write port; contents survive reset
    always_ff @(negedge I_CLOCK) begin
        if (!I_FRAMESTALL && I_WBEnable) rf[I_WBRegIdx] <= I_WBData;
    end

    // DE/EX latch and stall outputs
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            O_LOCK              <= 1'b0;
            O_DEValid           <= 1'b0;
            O_DepStallSignal    <= 1'b0;
            O_BranchStallSignal <= 1'b0;
            O_PC                <= '0;
            O_Opcode            <= OP_NOP;
            O_DestRegIdx        <= '0;
            O_Src1Value         <= '0;
            O_Src2Value         <= '0;
            O_Imm               <= '0;
        end else if (!I_FRAMESTALL) begin
            O_LOCK              <= I_LOCK;
            O_DEValid           <= valid_nxt;
            O_DepStallSignal    <= dep_nxt;
            O_BranchStallSignal <= br_nxt;
            if (issue_c) begin
                O_PC         <= I_PC;
                O_Opcode     <= opc;
                O_DestRegIdx <= dest_idx;
                O_Src1Value  <= src1_val_c;
                O_Src2Value  <= src2_val_c;
                O_Imm        <= imm;
            end else begin
                O_Opcode     <= OP_NOP;
            end
        end
    end

`ifdef DECODE_PERF_CNT_EN
    // Stall-cycle counters, wrapping
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            O_DepStallCycles <= '0;
            O_BrStallCycles  <= '0;
        end else if (!I_FRAMESTALL) begin
            if (O_DepStallSignal)    O_DepStallCycles <= O_DepStallCycles + 32'd1;
            if (O_BranchStallSignal) O_BrStallCycles  <= O_BrStallCycles + 32'd1;
        end
    end
`else
    assign O_DepStallCycles = '0;
    assign O_BrStallCycles  = '0;
`endif

endmodule
